// File: rtl/aes128_iter_ctrl.sv
// aes128_iter_ctrl: iterative AES-128 encryptor that runs one round per clock through one shared sub_byte.

// s_box: AES S-box computed as the GF(2^8) inverse (a^254) followed by the affine transform.
module s_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            p = z[i] ? p ^ t : p;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Square-and-multiply over a^2..a^128 gives a^254; zero maps to zero as the cipher requires.
    always_comb begin
        logic [7:0] sq;
        logic [7:0] inv;
        sq = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// sub_byte: SubBytes over the whole 16-byte state.
module sub_byte (
    input  logic [0:127] din,
    output logic [0:127] dout
);
    for (genvar i = 0; i < 16; i++) begin : g_sb
        s_box u_s_box (.a(din[8*i +: 8]), .y(dout[8*i +: 8]));
    end
endmodule

// aes128_iter_ctrl: control FSM, round/key registers and the linear round layers.
module aes128_iter_ctrl #(
    parameter int NR = 10,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_text,
    input  logic [0:127] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_text,
    output logic         busy
);
    if (NR != 10 || (1 << CW) <= NR) begin : g_bad_param
        $error("aes128_iter_ctrl: NR must be 10 and 2**CW must exceed NR");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t          fsm, fsm_nx;
    logic          rdy;
    logic [0:127]  state, rk, rk_next, sb_out, state_nx;
    logic [CW-1:0] round;
    logic [7:0]    rcon;
    logic [0:31]   rot, sw, t0, t1, t2, t3;
    logic          accept, last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[8*(4*c+w) +: 8] = s[8*(4*((c+w)%4)+w) +: 8];
        return r;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            r[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    sub_byte u_sub_byte (.din(state), .dout(sb_out));

    assign rot = {rk[104:127], rk[96:103]};
    for (genvar k = 0; k < 4; k++) begin : g_key_sbox
        s_box u_key_s_box (.a(rot[8*k +: 8]), .y(sw[8*k +: 8]));
    end
    assign t0 = rk[0:31] ^ sw ^ {rcon, 24'h0};
    assign t1 = rk[32:63] ^ t0;
    assign t2 = rk[64:95] ^ t1;
    assign t3 = rk[96:127] ^ t2;
    assign rk_next = {t0, t1, t2, t3};

    assign last = round == CW'(NR);
    assign state_nx = (last ? shift_rows(sb_out) : mix_columns(shift_rows(sb_out))) ^ rk_next;
    assign accept = rdy & in_valid;

    // Next-state decode; in_ready is only high in IDLE, so accept implies IDLE.
    always_comb begin
        fsm_nx = fsm;
        fsm_nx = fsm == IDLE  ? (accept ? ROUND : IDLE) :
                 fsm == ROUND ? (last ? DONE : ROUND) :
                 (out_ready ? IDLE : DONE);
    end

    // Control and datapath registers; in_ready trails IDLE entry by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm   <= IDLE;
            rdy   <= 1'b0;
            state <= '0;
            rk    <= '0;
            round <= '0;
            rcon  <= 8'h01;
        end else begin
            fsm <= fsm_nx;
            rdy <= fsm == IDLE && !accept;
            if (accept) begin
                state <= in_text ^ in_key;
                rk    <= in_key;
                round <= CW'(1);
                rcon  <= 8'h01;
            end else if (fsm == ROUND) begin
                state <= state_nx;
                rk    <= rk_next;
                round <= round + CW'(1);
                rcon  <= xtime(rcon);
            end
        end
    end

    assign in_ready  = rdy;
    assign out_valid = fsm == DONE;
    assign busy      = fsm != IDLE;
    assign out_text  = out_valid ? state : '0;
endmodule
